// File: rtl/mem_bus_arbiter_if.sv
// External memory bus between the IF/MEM arbiter (master) and the memory slave.
// The arbiter drives cycle/strobe/address/data and reports watchdog terminations on bus_err_o.
interface mem_bus_arbiter_if;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    modport master (
        output bus_cyc_o, bus_stb_o, bus_we_o, bus_addr_o, bus_sel_o, bus_data_o, bus_err_o,
        input  bus_data_i, bus_ack_i
    );

    modport slave (
        input  bus_cyc_o, bus_stb_o, bus_we_o, bus_addr_o, bus_sel_o, bus_data_o, bus_err_o,
        output bus_data_i, bus_ack_i
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding memory bus arbiter for the IF and MEM pipeline ports (MEM has priority).
// Each port's result is held until its stage advances; a watchdog ends transactions the slave never acks.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_stall_i,
    output logic [31:0] if_data_o,
    output logic        if_stallreq_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_stall_i,
    output logic [31:0] mem_data_o,
    output logic        mem_stallreq_o,
    mem_bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_BUSY  = 2'd1,
        ST_MEM_BUSY = 2'd2
    } state_e;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [7:0]  wdog_q, wdog_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_buf_q, if_buf_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_buf_q, mem_buf_d;
    logic [31:0] rdata_s;

    // Next-state logic: grant, completion/timeout, hold release and flush.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        wdata_d     = wdata_q;
        err_d       = 1'b0;
        wdog_d      = wdog_q;
        if_valid_d  = if_valid_q & if_stall_i;
        mem_valid_d = mem_valid_q & mem_stall_i;
        if_buf_d    = if_buf_q;
        mem_buf_d   = mem_buf_q;
        rdata_s     = 32'h0;

        if (flush_i) begin
            // Flush discards any ack arriving in the same cycle.
            state_d     = ST_IDLE;
            cyc_d       = 1'b0;
            we_d        = 1'b0;
            wdog_d      = 8'd0;
            if_valid_d  = 1'b0;
            mem_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_req_i && !mem_valid_q) begin
                        state_d = ST_MEM_BUSY;
                        cyc_d   = 1'b1;
                        we_d    = mem_we_i;
                        addr_d  = mem_addr_i;
                        sel_d   = mem_sel_i;
                        wdata_d = mem_data_i;
                        wdog_d  = 8'd0;
                    end else if (if_req_i && !if_valid_q) begin
                        state_d = ST_IF_BUSY;
                        cyc_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = if_addr_i;
                        sel_d   = 4'b1111;
                        wdata_d = 32'h0;
                        wdog_d  = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_IF_BUSY, ST_MEM_BUSY: begin
                    if (bus.bus_ack_i || (wdog_q == WDOG_LAST)) begin
                        rdata_s = (bus.bus_ack_i && !we_q) ? bus.bus_data_i : 32'h0;
                        err_d   = ~bus.bus_ack_i;
                        state_d = ST_IDLE;
                        cyc_d   = 1'b0;
                        we_d    = 1'b0;
                        if (state_q == ST_MEM_BUSY) begin
                            mem_valid_d = 1'b1;
                            mem_buf_d   = rdata_s;
                        end else begin
                            if_valid_d  = 1'b1;
                            if_buf_d    = rdata_s;
                        end
                    end else begin
                        wdog_d = wdog_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                end
            endcase
        end
    end

    // State and hold registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            sel_q       <= 4'h0;
            wdata_q     <= 32'h0;
            err_q       <= 1'b0;
            wdog_q      <= 8'd0;
            if_valid_q  <= 1'b0;
            if_buf_q    <= 32'h0;
            mem_valid_q <= 1'b0;
            mem_buf_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            wdog_q      <= wdog_d;
            if_valid_q  <= if_valid_d;
            if_buf_q    <= if_buf_d;
            mem_valid_q <= mem_valid_d;
            mem_buf_q   <= mem_buf_d;
        end
    end

    assign bus.bus_cyc_o  = cyc_q;
    assign bus.bus_stb_o  = cyc_q;
    assign bus.bus_we_o   = we_q;
    assign bus.bus_addr_o = addr_q;
    assign bus.bus_sel_o  = sel_q;
    assign bus.bus_data_o = wdata_q;
    assign bus.bus_err_o  = err_q;

    assign if_stallreq_o  = if_req_i & ~if_valid_q;
    assign mem_stallreq_o = mem_req_i & ~mem_valid_q;
    assign if_data_o      = if_buf_q;
    assign mem_data_o     = mem_buf_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external memory bus between the instruction-fetch port (IF) and the data-memory port (MEM) of the five-stage pipeline. It runs one bus transaction at a time, gives MEM priority over IF, and holds each port's result until the pipeline advances. It drives per-port stall requests into the pipeline stall controller and aborts on exception flush. A watchdog terminates transactions whose slave never acknowledges.

## Interface
- TIMEOUT, default 255: bus cycles without `bus_ack_i` before forced termination; range 1..255.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush_i  in  1  exception flush from the stall controller.
- if_req_i  in  1  IF read request.
- if_addr_i  in  32  IF word address.
- if_stall_i  in  1  IF stage stalled (stall[1]).
- if_data_o  out  32  fetched instruction, valid while `if_stallreq_o`=0 and `if_req_i`=1.
- if_stallreq_o  out  1  IF stall request.
- mem_req_i  in  1  MEM request (load or store).
- mem_we_i  in  1  1 = store.
- mem_addr_i  in  32  MEM address.
- mem_sel_i  in  4  byte lanes.
- mem_data_i  in  32  store data.
- mem_stall_i  in  1  MEM stage stalled (stall[4]).
- mem_data_o  out  32  load data.
- mem_stallreq_o  out  1  MEM stall request.
- bus_cyc_o, bus_stb_o  out  1  cycle/strobe, always driven equal.
- bus_we_o  out  1  write enable.
- bus_addr_o  out  32  address.
- bus_sel_o  out  4  byte select; 4'b1111 for IF.
- bus_data_o  out  32  write data; 0 for IF.
- bus_data_i  in  32  read data.
- bus_ack_i  in  1  slave acknowledge.
- bus_err_o  out  1  one-cycle pulse on timeout.

## Operation
- Bus FSM states: IDLE, IF_BUSY, MEM_BUSY. Per-port hold registers: `if_valid`/`if_buf`, `mem_valid`/`mem_buf`.
- IDLE, no flush: if `mem_req_i` & ~`mem_valid`, go to MEM_BUSY and latch addr/we/sel/data onto the bus registers. Otherwise, if `if_req_i` & ~`if_valid`, go to IF_BUSY with IF addr, we=0, sel=1111. Otherwise stay.
- BUSY: `bus_cyc_o`=`bus_stb_o`=1; bus outputs are frozen and requester input changes are ignored.
  - On `bus_ack_i`: drop cyc/stb, load `bus_data_i` into the owner's buffer (stores load 0), set the owner's valid, return to IDLE.
- Watchdog: 8-bit counter cleared on grant, incremented each BUSY cycle without ack.
  - At count == TIMEOUT-1 with no ack: terminate as if acked with data 32'h0 and pulse `bus_err_o`.
- Hold release: a set valid clears on any edge where its stall input is 0. That is the pipeline advance edge.
- `if_stallreq_o` = `if_req_i` & ~`if_valid`. `mem_stallreq_o` = `mem_req_i` & ~`mem_valid`. Both are combinational from registers and inputs.
- `if_data_o`=`if_buf`, `mem_data_o`=`mem_buf`.
- A valid port stays valid while the other port uses the bus, so there is no deadlock when MEM stalls IF.
- Flush (highest priority): next state IDLE, cyc/stb/we=0, both valids cleared, watchdog cleared. An ack in the same cycle is discarded, and there is no `bus_err_o`.
- A request withdrawn mid-transaction (no flush) still completes; its result is stored and released on the next advance edge.
- Reset: state IDLE; all bus outputs 0; valids 0; buffers 0; `bus_err_o` 0; counter 0. The stall requests then follow the request inputs.

## Timing
- Grant decision in IDLE at edge N; cyc/stb high from N+1.
- Zero-wait slave (ack in first BUSY cycle): valid and buffer set at edge N+2, stall request low from N+2. Minimum latency is 2 cycles.
- Each wait state adds 1 cycle. At most one transaction is in flight.
- Back-to-back: IDLE follows every completion, so the next grant happens at that edge and a new strobe starts 1 cycle later. Minimum gap is 1 cycle with cyc low.
- Simultaneous requests in IDLE: MEM is granted; IF is granted at the next IDLE.
- Timeout: with TIMEOUT=T, termination occurs at the edge ending the T-th BUSY cycle; `bus_err_o` is high for the following cycle.

## Test plan
- IF only, zero-wait slave returns 32'h2402_0005: cyc high for 1 cycle, `if_stallreq_o` high for 2 cycles, `if_data_o`=32'h2402_0005. Valid clears on the first edge with `if_stall_i`=0.
- IF and MEM request together, MEM store addr 0x100, sel 0011, data 0xABCD: MEM bus cycle first with we=1, sel=0011. The IF read follows 1 idle cycle later. `mem_data_o`=0.
- IF completed and held with `if_stall_i`=1 while MEM load takes 3 wait states: `if_data_o` is held unchanged throughout, and MEM completes after 5 cycles.
- Flush asserted on the same cycle as ack of a MEM load: the ack is discarded, `mem_valid`=0, and the bus is idle next cycle with no `bus_err_o`.
- Slave never acks, TIMEOUT=4: cyc drops after 4 cycles, `bus_err_o` pulses once, and the port receives data 0 with its stall request low.
- `rst` asserted mid-transaction: next cycle all bus outputs are 0, valids are 0, and the FSM is IDLE. A subsequent request behaves as the first test.
